ysyx22041405_ifu: RTL

//   Instruction fetch unit, directly upstream of the LSU/decode path. Holds the PC,

---
 rtl/ysyx22041405_ifu_if.sv | 31 +++
 rtl/ysyx22041405_ifu.sv | 130 +++++++++++++
 2 files changed

// File: rtl/ysyx22041405_ifu_if.sv
// Fetch-unit bus bundle: the memory request/response channel, the decode-side
// output channel and the redirect input, seen from the IFU (master) or its environment (slave).
interface ysyx22041405_ifu_if #(
    parameter int WIDTH = 32
);
    logic             req_valid;
    logic             req_ready;
    logic [WIDTH-1:0] req_addr;
    logic             resp_valid;
    logic [WIDTH-1:0] resp_data;
    logic             resp_err;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_pc;
    logic [WIDTH-1:0] out_inst;
    logic             out_fault;
    logic             redirect_valid;
    logic [WIDTH-1:0] redirect_pc;

    modport master (
        output req_valid, req_addr, out_valid, out_pc, out_inst, out_fault,
        input  req_ready, resp_valid, resp_data, resp_err, out_ready,
               redirect_valid, redirect_pc
    );

    modport slave (
        input  req_valid, req_addr, out_valid, out_pc, out_inst, out_fault,
        output req_ready, resp_valid, resp_data, resp_err, out_ready,
               redirect_valid, redirect_pc
    );
endinterface

// File: rtl/ysyx22041405_ifu.sv
// Instruction fetch unit: owns the PC, keeps at most one fetch in flight and
// hands {pc, inst, fault} to decode; redirects retarget or discard the fetch in progress.
module ysyx22041405_ifu #(
    parameter int               WIDTH    = 32,
    parameter logic [WIDTH-1:0] RESET_PC = WIDTH'(32'h8000_0000)
) (
    input logic                clk,
    input logic                rst_n,
    ysyx22041405_ifu_if.master bus
);
    typedef enum logic [2:0] {
        ST_RST,
        ST_REQ,
        ST_WAIT,
        ST_HOLD,
        ST_HALT
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] pc_q, pc_d;
    logic [WIDTH-1:0] out_pc_q, out_pc_d;
    logic [WIDTH-1:0] out_inst_q, out_inst_d;
    logic             out_fault_q, out_fault_d;
    logic             discard_q, discard_d;
    logic             misaligned;

    assign misaligned   = (pc_q[1:0] != 2'b00);
    assign bus.req_addr = pc_q;
    assign bus.out_pc   = out_pc_q;
    assign bus.out_inst = out_inst_q;
    assign bus.out_fault = out_fault_q;

    always_comb begin
        // NOTE: every signal written here gets a default first, so no path can infer a latch.
        state_d       = state_q;
        pc_d          = pc_q;
        out_pc_d      = out_pc_q;
        out_inst_d    = out_inst_q;
        out_fault_d   = out_fault_q;
        discard_d     = discard_q;
        bus.req_valid = 1'b0;
        bus.out_valid = 1'b0;

        case (state_q)
            ST_RST: state_d = ST_REQ;

            ST_REQ: begin
                bus.req_valid = !misaligned;
                if (bus.redirect_valid) begin
                    pc_d = bus.redirect_pc;
                end
                if (misaligned) begin
                    if (!bus.redirect_valid) begin
                        state_d     = ST_HOLD;
                        out_pc_d    = pc_q;
                        out_inst_d  = '0;
                        out_fault_d = 1'b1;
                    end
                end else if (bus.req_ready) begin
                    // A redirect racing the accept leaves a stale fetch in flight.
                    state_d   = ST_WAIT;
                    discard_d = bus.redirect_valid;
                end
            end

            ST_WAIT: begin
                if (bus.redirect_valid) begin
                    pc_d = bus.redirect_pc;
                end
                if (bus.resp_valid) begin
                    discard_d = 1'b0;
                    if (discard_q || bus.redirect_valid) begin
                        state_d = ST_REQ;
                    end else begin
                        state_d     = ST_HOLD;
                        out_pc_d    = pc_q;
                        out_inst_d  = bus.resp_err ? '0 : bus.resp_data;
                        out_fault_d = bus.resp_err;
                    end
                end else if (bus.redirect_valid) begin
                    discard_d = 1'b1;
                end
            end

            ST_HOLD: begin
                bus.out_valid = 1'b1;
                if (bus.redirect_valid) begin
                    pc_d    = bus.redirect_pc;
                    state_d = ST_REQ;
                end else if (bus.out_ready) begin
                    if (out_fault_q) begin
                        state_d = ST_HALT;
                    end else begin
                        pc_d    = pc_q + WIDTH'(4);
                        state_d = ST_REQ;
                    end
                end
            end

            ST_HALT: begin
                if (bus.redirect_valid) begin
                    pc_d        = bus.redirect_pc;
                    out_fault_d = 1'b0;
                    state_d     = ST_REQ;
                end
            end

            default: state_d = ST_RST;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_RST;
            pc_q        <= RESET_PC;
            out_pc_q    <= '0;
            out_inst_q  <= '0;
            out_fault_q <= 1'b0;
            discard_q   <= 1'b0;
        end else begin
            // NOTE: non-blocking updates so every flop samples the pre-edge values.
            state_q     <= state_d;
            pc_q        <= pc_d;
            out_pc_q    <= out_pc_d;
            out_inst_q  <= out_inst_d;
            out_fault_q <= out_fault_d;
            discard_q   <= discard_d;
        end
    end
endmodule
